// File: rtl/pixel_scheduler.sv
// Round-robin dispatch of raster-order pixel jobs to NUM_CORES raymarcher cores,
// with per-core result slots merged round-robin onto one frame-buffer write port.
module pixel_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 3,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  output logic [NUM_CORES-1:0]    core_start_out,
  output logic [XW-1:0]           job_x_out,
  output logic [YW-1:0]           job_y_out,
  input  logic [NUM_CORES-1:0]    core_done_in,
  input  logic [24*NUM_CORES-1:0] core_color_in,
  input  logic [XW*NUM_CORES-1:0] core_x_in,
  input  logic [YW*NUM_CORES-1:0] core_y_in,
  output logic                    frame_we_out,
  output logic [AW-1:0]           frame_addr_out,
  output logic [23:0]             frame_color_out,
  output logic                    frame_start_out,
  output logic [31:0]             frame_count_out
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  // Returns {hit, index} of the first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int k;
    res = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      k = int'(ptr) + j;
      if (k >= NUM_CORES) k = k - NUM_CORES;
      if (req[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
    if (int'(idx) == NUM_CORES - 1) return '0;
    return idx + 1'b1;
  endfunction

  logic [XW-1:0]        x_cnt;
  logic [YW-1:0]        y_cnt;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] slot_valid;
  logic [23:0]          slot_color [NUM_CORES];
  logic [XW-1:0]        slot_x     [NUM_CORES];
  logic [YW-1:0]        slot_y     [NUM_CORES];
  logic [PW-1:0]        disp_ptr;
  logic [PW-1:0]        wr_ptr;

  logic [PW:0]   disp_sel;
  logic [PW:0]   wr_sel;
  logic [PW-1:0] disp_idx;
  logic [PW-1:0] wr_idx;
  logic          disp_go;
  logic          wr_go;
  logic [AW-1:0] wr_addr;

  // A core with an undrained result is not eligible, so its slot can never be overwritten.
  assign disp_sel = rr_pick(~busy & ~slot_valid, disp_ptr);
  assign wr_sel   = rr_pick(slot_valid, wr_ptr);
  assign disp_idx = disp_sel[PW-1:0];
  assign wr_idx   = wr_sel[PW-1:0];
  assign disp_go  = enable_in & disp_sel[PW];
  assign wr_go    = wr_sel[PW];
  assign wr_addr  = AW'(slot_x[wr_idx]) + AW'(WIDTH) * AW'(slot_y[wr_idx]);

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_done_in[i] && busy[i]) begin
        slot_color[i] <= core_color_in[24*i +: 24];
        slot_x[i]     <= core_x_in[XW*i +: XW];
        slot_y[i]     <= core_y_in[YW*i +: YW];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_cnt           <= '0;
      y_cnt           <= '0;
      busy            <= '0;
      slot_valid      <= '0;
      disp_ptr        <= '0;
      wr_ptr          <= '0;
      core_start_out  <= '0;
      job_x_out       <= '0;
      job_y_out       <= '0;
      frame_we_out    <= 1'b0;
      frame_addr_out  <= '0;
      frame_color_out <= '0;
      frame_start_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      core_start_out  <= '0;
      frame_start_out <= 1'b0;
      frame_we_out    <= 1'b0;

      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_done_in[i] && busy[i]) begin
          slot_valid[i] <= 1'b1;
          busy[i]       <= 1'b0;
        end
      end

      if (disp_go) begin
        core_start_out   <= NUM_CORES'(1) << disp_idx;
        job_x_out        <= x_cnt;
        job_y_out        <= y_cnt;
        frame_start_out  <= (x_cnt == '0) && (y_cnt == '0);
        busy[disp_idx]   <= 1'b1;
        disp_ptr         <= ptr_next(disp_idx);
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          if (y_cnt == Y_LAST) begin
            y_cnt           <= '0;
            frame_count_out <= frame_count_out + 32'd1;
          end else begin
            y_cnt <= y_cnt + 1'b1;
          end
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      // Drain one slot per cycle; its flag clears on the same edge the write is issued.
      if (wr_go) begin
        frame_we_out       <= 1'b1;
        frame_addr_out     <= wr_addr;
        frame_color_out    <= slot_color[wr_idx];
        slot_valid[wr_idx] <= 1'b0;
        wr_ptr             <= ptr_next(wr_idx);
      end
    end
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler: model cores answer after a fixed delay with random colours,
// and a scoreboard of produced results is matched against frame-buffer writes.
module tb_pixel_scheduler;
  localparam int W = 4, H = 2, N = 3;
  localparam int XW = 2, YW = 1, AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [N-1:0]      core_start;
  logic [XW-1:0]     job_x;
  logic [YW-1:0]     job_y;
  logic [N-1:0]      core_done;
  logic [24*N-1:0]   core_color;
  logic [XW*N-1:0]   core_x;
  logic [YW*N-1:0]   core_y;
  logic              frame_we;
  logic [AW-1:0]     frame_addr;
  logic [23:0]       frame_color;
  logic              frame_start;
  logic [31:0]       frame_count;

  always #5 clk = ~clk;

  pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable),
    .core_start_out(core_start), .job_x_out(job_x), .job_y_out(job_y),
    .core_done_in(core_done), .core_color_in(core_color),
    .core_x_in(core_x), .core_y_in(core_y),
    .frame_we_out(frame_we), .frame_addr_out(frame_addr),
    .frame_color_out(frame_color), .frame_start_out(frame_start),
    .frame_count_out(frame_count)
  );

  typedef struct {int core; int addr; logic [23:0] color;} res_t;

  int          checks = 0;
  int          failures = 0;
  int          n = 0;
  logic [31:0] fc = '0;
  bit          auto_mode = 1'b0;
  int          cd [N];
  int          cjx [N];
  int          cjy [N];
  bit          busy_m [N];
  bit          pend [N];
  bit [N-1:0]  man_done = '0;
  logic [23:0] man_color [N];
  res_t        sb [$];
  int          wcount [W*H];
  int          writes_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_done(input int i, input logic [23:0] c);
    core_done[i]          = 1'b1;
    core_color[24*i +: 24] = c;
    core_x[XW*i +: XW]    = XW'(cjx[i]);
    core_y[YW*i +: YW]    = YW'(cjy[i]);
    if (busy_m[i]) begin
      sb.push_back('{core: i, addr: cjx[i] + W * cjy[i], color: c});
      busy_m[i] = 1'b0;
    end
  endtask

  function automatic int outstanding();
    int c;
    c = sb.size();
    for (int i = 0; i < N; i++) c += int'(busy_m[i]);
    return c;
  endfunction

  // One clock: sample at the falling edge, update the model, then drive core responses.
  task automatic tick();
    int  k;
    bit  found;
    @(negedge clk);
    if (core_start !== '0) begin
      chk("start_onehot", 64'($onehot(core_start)), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (core_start[i]) begin
          chk("start_not_pending", 64'(pend[i]), 64'd0);
          pend[i] = 1'b1;
          busy_m[i] = 1'b1;
          cjx[i] = n % W;
          cjy[i] = (n / W) % H;
          if (auto_mode) cd[i] = 5;
        end
      end
      chk("job_x", 64'(job_x), 64'(n % W));
      chk("job_y", 64'(job_y), 64'((n / W) % H));
      chk("frame_start", 64'(frame_start), 64'((n % (W*H)) == 0));
      if (n % (W*H) == W*H - 1) fc++;
      n++;
    end else begin
      chk("frame_start_idle", 64'(frame_start), 64'd0);
    end
    chk("frame_count", 64'(frame_count), 64'(fc));
    if (frame_we === 1'b1) begin
      found = 1'b0;
      k = 0;
      foreach (sb[j]) begin
        if (!found && sb[j].addr == int'(frame_addr) && sb[j].color == frame_color) begin
          found = 1'b1;
          k = j;
        end
      end
      chk("write_expected", 64'(found), 64'd1);
      if (found) begin
        pend[sb[k].core] = 1'b0;
        wcount[sb[k].addr]++;
        sb.delete(k);
      end
      writes_seen++;
    end
    core_done = '0;
    for (int i = 0; i < N; i++) begin
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) drive_done(i, 24'($urandom));
      end
      if (man_done[i]) drive_done(i, man_color[i]);
    end
    man_done = '0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (outstanding() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk(tag, 64'(outstanding()), 64'd0);
  endtask

  initial begin
    logic [23:0] ca, cb, cc;
    int g, ws;
    rst = 1'b1; enable = 1'b0;
    core_done = '0; core_color = '0; core_x = '0; core_y = '0;
    for (int i = 0; i < N; i++) begin
      cd[i] = 0; cjx[i] = 0; cjy[i] = 0; busy_m[i] = 1'b0; pend[i] = 1'b0; man_color[i] = '0;
    end
    for (int a = 0; a < W*H; a++) wcount[a] = 0;

    repeat (2) tick();
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_job_x", 64'(job_x), 64'd0);
    chk("rst_job_y", 64'(job_y), 64'd0);
    chk("rst_we", 64'(frame_we), 64'd0);
    chk("rst_addr", 64'(frame_addr), 64'd0);
    chk("rst_color", 64'(frame_color), 64'd0);
    chk("rst_fstart", 64'(frame_start), 64'd0);
    chk("rst_fcount", 64'(frame_count), 64'd0);

    // Reset then enable: three consecutive grants in order
    rst = 1'b0; enable = 1'b1;
    tick();
    chk("t1_start0", 64'(core_start), 64'b001);
    chk("t1_fs0", 64'(frame_start), 64'd1);
    tick();
    chk("t1_start1", 64'(core_start), 64'b010);
    chk("t1_x1", 64'(job_x), 64'd1);
    tick();
    chk("t1_start2", 64'(core_start), 64'b100);
    chk("t1_x2", 64'(job_x), 64'd2);
    enable = 1'b0;

    // Simultaneous done on all cores
    tick(); tick();
    ca = 24'($urandom); cb = 24'($urandom); cc = 24'($urandom);
    man_color[0] = ca; man_color[1] = cb; man_color[2] = cc;
    man_done = 3'b111;
    tick();
    tick();
    chk("t2_c1_we", 64'(frame_we), 64'd0);
    tick();
    chk("t2_we0", 64'(frame_we), 64'd1);
    chk("t2_addr0", 64'(frame_addr), 64'd0);
    chk("t2_color0", 64'(frame_color), 64'(ca));
    tick();
    chk("t2_we1", 64'(frame_we), 64'd1);
    chk("t2_addr1", 64'(frame_addr), 64'd1);
    chk("t2_color1", 64'(frame_color), 64'(cb));
    tick();
    chk("t2_we2", 64'(frame_we), 64'd1);
    chk("t2_addr2", 64'(frame_addr), 64'd2);
    chk("t2_color2", 64'(frame_color), 64'(cc));
    tick();
    chk("t2_we_end", 64'(frame_we), 64'd0);

    // Two full frames with auto-responding cores
    auto_mode = 1'b1; enable = 1'b1;
    g = 0;
    while (n < 16 && g < 400) begin tick(); g++; end
    enable = 1'b0;
    chk("t3_dispatched", 64'(n), 64'd16);
    drain("t3_drain");
    chk("t3_fcount", 64'(frame_count), 64'd2);
    for (int a = 0; a < W*H; a++) chk("t3_wcount", 64'(wcount[a]), 64'd2);

    // Stray done from an idle core
    man_color[1] = 24'($urandom);
    man_done = 3'b010;
    tick();
    repeat (4) begin
      tick();
      chk("t4_no_write", 64'(frame_we), 64'd0);
    end

    // enable low mid-frame
    enable = 1'b1;
    g = 0;
    while (n < 18 && g < 50) begin tick(); g++; end
    enable = 1'b0;
    ws = writes_seen;
    repeat (12) begin
      tick();
      chk("t5_no_start", 64'(core_start), 64'd0);
    end
    chk("t5_drained", 64'(writes_seen - ws), 64'd2);
    enable = 1'b1;
    tick();
    chk("t5_resume_start", 64'(core_start != '0), 64'd1);
    chk("t5_resume_x", 64'(job_x), 64'd2);
    chk("t5_resume_y", 64'(job_y), 64'd0);

    // Asynchronous reset mid-operation
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_fcount", 64'(frame_count), 64'd0);
    chk("t6_async_start", 64'(core_start), 64'd0);
    chk("t6_async_job_x", 64'(job_x), 64'd0);
    chk("t6_async_job_y", 64'(job_y), 64'd0);
    chk("t6_async_we", 64'(frame_we), 64'd0);
    chk("t6_async_addr", 64'(frame_addr), 64'd0);
    chk("t6_async_color", 64'(frame_color), 64'd0);
    chk("t6_async_fstart", 64'(frame_start), 64'd0);
    n = 0; fc = '0; enable = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 1'b0; pend[i] = 1'b0; cd[i] = 0;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) man_color[i] = 24'($urandom);
    man_done = 3'b111;
    tick();
    repeat (3) begin
      tick();
      chk("t6_late_done_ignored", 64'(frame_we), 64'd0);
    end
    enable = 1'b1;
    tick();
    chk("t6_restart_core", 64'(core_start), 64'b001);
    chk("t6_restart_x", 64'(job_x), 64'd0);
    chk("t6_restart_y", 64'(job_y), 64'd0);
    chk("t6_restart_fs", 64'(frame_start), 64'd1);
    g = 0;
    while (n < 10 && g < 200) begin tick(); g++; end
    enable = 1'b0;
    drain("t6_drain");
    chk("t6_fcount", 64'(frame_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_scheduler.md
# pixel_scheduler

Dispatches raster-order pixel jobs to NUM_CORES raymarcher cores and merges their results onto the single frame-buffer write port. It sits between the camera-vector latch and the raymarcher array in the renderer. It replaces the one-core start/done loop and allows 1..8 cores to share the frame buffer. It also produces the per-frame timer and a frame-start strobe that the renderer uses to latch new camera vectors.

## Interface
- WIDTH, 1280, image width in pixels
- HEIGHT, 720, image height in pixels
- NUM_CORES, 3, number of raymarcher cores (1..8)
- Derived: XW = $clog2(WIDTH), YW = $clog2(HEIGHT), AW = $clog2(WIDTH*HEIGHT)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; **one clock; reset is asynchronous and active-high**
- enable_in  in  1  when low, no new dispatches; in-flight results still drain
- core_start_out  out  NUM_CORES  one-hot, one-cycle start pulse per core
- job_x_out  out  XW  pixel x; valid while any core_start_out bit is high
- job_y_out  out  YW  pixel y; valid while any core_start_out bit is high
- core_done_in  in  NUM_CORES  per-core one-cycle done pulse
- core_color_in  in  24*NUM_CORES  core i color at [24i+23:24i]
- core_x_in  in  XW*NUM_CORES  core i result x
- core_y_in  in  YW*NUM_CORES  core i result y
- frame_we_out  out  1  frame-buffer write enable
- frame_addr_out  out  AW  x + WIDTH*y
- frame_color_out  out  24  write data
- frame_start_out  out  1  pulse when pixel (0,0) is dispatched
- frame_count_out  out  32  completed-frame dispatch counter (timer)

## Operation
- Per-core state:
  - `busy[i]`: set on dispatch, cleared on done.
  - `slot_valid[i]` plus a slot holding color, x and y.
- A core is eligible when `!busy[i] && !slot_valid[i]`. A core is never re-dispatched while its result is still pending.
- Dispatch:
  - At most one per cycle, only when enable_in = 1.
  - The grant is round-robin among eligible cores. The dispatch pointer moves to one past the granted index.
  - The granted core gets the current (x,y); then the raster counter advances.
  - x wraps at WIDTH-1 to 0 and increments y. y wraps at HEIGHT-1 to 0.
- Dispatch of (0,0) raises frame_start_out.
- Dispatch of (WIDTH-1,HEIGHT-1) increments frame_count_out. The counter wraps modulo 2^32.
- Done handling:
  - If core_done_in[i] is high and busy[i] is set, the slot captures core i's color, x and y. Then slot_valid[i] is set and busy[i] is cleared.
  - A done from a non-busy core is ignored.
- Write arbitration:
  - Each cycle, round-robin over valid slots using its own pointer, independent of the dispatch pointer.
  - The winner drives the frame_* outputs (registered), and its slot_valid is cleared on the same edge.
- Simultaneous events:
  - Done on several cores in one cycle: all are captured, then drained one per cycle.
  - A dispatch and a drain in the same cycle are both legal.
- Address arithmetic: AW-bit unsigned, computed from the slot's x and y, not from the dispatch counter.

## Timing
- Reset (asynchronous): all outputs are 0, the raster counter is (0,0), both pointers are 0, and all busy and slot_valid flags are cleared. Results arriving from pre-reset jobs are ignored.
- First dispatch: on the first rising edge after rst_in falls, with enable_in = 1. core_start_out = 001, job = (0,0) and frame_start_out = 1 in the following cycle.
- All outputs are registered. Start, frame_start and frame_we are single-cycle pulses.
- Latency: with core_done_in[i] high in cycle c, the earliest frame_we_out is cycle c+2.
- With k slots contending, the last write occurs by c+1+k.
- The earliest re-dispatch of a core is the cycle after its slot drains.
- Throughput: 1 dispatch and 1 write per cycle maximum.
- enable_in falling mid-frame: dispatch stops at the current (x,y) and resumes from it. Pending slots keep draining.

## Test plan
Use WIDTH=4, HEIGHT=2, NUM_CORES=3, with a model core that responds 5 cycles after start.
1. **Reset then enable**: starts are 001 (0,0), 010 (1,0), 100 (2,0) on consecutive cycles. frame_start_out pulses only with (0,0).
2. **Simultaneous done**: all three cores signal done in cycle c with colors A, B, C. Writes occur at c+2, c+3, c+4 with addresses 0, 1, 2 in round-robin order, and nothing is lost.
3. **Wrap-around**: run 2 full frames. frame_count_out reads 1 after dispatch of (3,1), then 2. The dispatch after (3,1) is (0,0) with frame_start_out = 1. Addresses 0..7 are each written once per frame.
4. **Stray done**: pulse core_done_in[1] while core 1 is idle. No write occurs and no state changes.
5. **enable_in low**: drop enable_in after dispatching (1,0). No starts occur, but the 2 pending results are still written. On re-enable, the next job is (2,0).
6. **Reset mid-operation**: assert rst_in asynchronously while a core is busy. All outputs go to 0 immediately, late done pulses are ignored, and after release the dispatch restarts at (0,0) on core 0.
